// File: rtl/ysyx_23060075_trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, mstatus bit
// positions and the sequencer state type.
package ysyx_23060075_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MCAUSE_ECALL_M = 11;

    typedef enum logic [2:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWStat,
        StRVec,
        StRStat,
        StREpc,
        StDone
    } trap_state_e;

endpackage

// File: rtl/ysyx_23060075_register.sv
// Generic enable-gated register with asynchronous active-high reset.
module ysyx_23060075_register #(
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060075_trap_ctrl.sv
// Trap sequencer: turns ecall/mret into single-port CSR accesses and a PC redirect;
// forwards core Zicsr accesses while idle.
module ysyx_23060075_trap_ctrl
    import ysyx_23060075_trap_ctrl_pkg::*;
#(
    parameter int unsigned MCAUSE_ECALL = MCAUSE_ECALL_M,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned AW           = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic            trap_is_mret,
    input  logic [XLEN-1:0] trap_pc,
    output logic            trap_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic [AW-1:0]   core_csr_addr,
    input  logic [XLEN-1:0] core_csr_w,
    input  logic            core_csr_w_en,
    output logic [XLEN-1:0] core_csr_r,
    output logic            core_stall,
    output logic [AW-1:0]   csr_addr,
    output logic [XLEN-1:0] csr_w,
    output logic            csr_w_en,
    input  logic [XLEN-1:0] csr_r
);

    localparam trap_state_e RESET_STATE = StIdle;

    logic [2:0]      state_raw;
    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            pc_wen;
    logic [XLEN-1:0] rpc_d;
    logic            rpc_wen;
    logic            rvalid_d;
    logic [XLEN-1:0] stat_w;

    assign state_q = trap_state_e'(state_raw);

    ysyx_23060075_register #(.WIDTH(3), .RESET_VAL(RESET_STATE)) u_state (
        .clk  (clk),
        .rst  (rst),
        .din  (state_d),
        .dout (state_raw),
        .wen  (1'b1)
    );

    ysyx_23060075_register #(.WIDTH(XLEN), .RESET_VAL('0)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .din  (trap_pc),
        .dout (pc_q),
        .wen  (pc_wen)
    );

    ysyx_23060075_register #(.WIDTH(XLEN), .RESET_VAL('0)) u_rpc (
        .clk  (clk),
        .rst  (rst),
        .din  (rpc_d),
        .dout (redirect_pc),
        .wen  (rpc_wen)
    );

    ysyx_23060075_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_rvalid (
        .clk  (clk),
        .rst  (rst),
        .din  (rvalid_d),
        .dout (redirect_valid),
        .wen  (1'b1)
    );

    always_comb begin
        state_d    = state_q;
        pc_wen     = 1'b0;
        rpc_d      = redirect_pc;
        rpc_wen    = 1'b0;
        rvalid_d   = 1'b0;
        stat_w     = csr_r;
        csr_addr   = '0;
        csr_w      = '0;
        csr_w_en   = 1'b0;
        core_csr_r = '0;
        core_stall = 1'b1;
        trap_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                trap_ready = 1'b1;
                if (trap_valid) begin
                    pc_wen  = 1'b1;
                    state_d = trap_is_mret ? StRStat : StWEpc;
                end else begin
                    csr_addr   = core_csr_addr;
                    csr_w      = core_csr_w;
                    csr_w_en   = core_csr_w_en;
                    core_csr_r = csr_r;
                    core_stall = 1'b0;
                end
            end
            StWEpc: begin
                csr_addr = AW'(CSR_MEPC);
                csr_w    = pc_q;
                csr_w_en = 1'b1;
                state_d  = StWCause;
            end
            StWCause: begin
                csr_addr = AW'(CSR_MCAUSE);
                csr_w    = XLEN'(MCAUSE_ECALL);
                csr_w_en = 1'b1;
                state_d  = StWStat;
            end
            StWStat: begin
                // Read-modify-write in one cycle: csr_r is combinational on csr_addr.
                csr_addr                              = AW'(CSR_MSTATUS);
                stat_w[MSTATUS_MPIE]                  = csr_r[MSTATUS_MIE];
                stat_w[MSTATUS_MIE]                   = 1'b0;
                stat_w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                csr_w                                 = stat_w;
                csr_w_en                              = 1'b1;
                state_d                               = StRVec;
            end
            StRVec: begin
                csr_addr = AW'(CSR_MTVEC);
                rpc_d    = {csr_r[XLEN-1:2], 2'b00};
                rpc_wen  = 1'b1;
                rvalid_d = 1'b1;
                state_d  = StDone;
            end
            StRStat: begin
                csr_addr                              = AW'(CSR_MSTATUS);
                stat_w[MSTATUS_MIE]                   = csr_r[MSTATUS_MPIE];
                stat_w[MSTATUS_MPIE]                  = 1'b1;
                stat_w[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
                csr_w                                 = stat_w;
                csr_w_en                              = 1'b1;
                state_d                               = StREpc;
            end
            StREpc: begin
                csr_addr = AW'(CSR_MEPC);
                rpc_d    = csr_r;
                rpc_wen  = 1'b1;
                rvalid_d = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060075_trap_ctrl.sv
// Directed bench for the trap sequencer with a CSR file model and a
// per-cycle sequence model of the expected CSR traffic.
module tb_ysyx_23060075_trap_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic        trap_is_mret = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        trap_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] core_csr_addr = '0;
    logic [31:0] core_csr_w = '0;
    logic        core_csr_w_en = 1'b0;
    logic [31:0] core_csr_r;
    logic        core_stall;
    logic [11:0] csr_addr;
    logic [31:0] csr_w;
    logic        csr_w_en;
    logic [31:0] csr_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060075_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_is_mret   (trap_is_mret),
        .trap_pc        (trap_pc),
        .trap_ready     (trap_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .core_csr_addr  (core_csr_addr),
        .core_csr_w     (core_csr_w),
        .core_csr_w_en  (core_csr_w_en),
        .core_csr_r     (core_csr_r),
        .core_stall     (core_stall),
        .csr_addr       (csr_addr),
        .csr_w          (csr_w),
        .csr_w_en       (csr_w_en),
        .csr_r          (csr_r)
    );

    // CSR file: combinational read, write on the clock edge
    logic [31:0] mem [0:4095];
    assign csr_r = mem[csr_addr];
    always @(posedge clk) begin
        if (csr_w_en) mem[csr_addr] <= csr_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sequence model: k = cycle index since acceptance (0 = idle)
    int          k = 0;
    int          last = 0;
    logic [11:0] exp_addr [1:5];
    logic [31:0] exp_w    [1:5];
    logic        exp_wen  [1:5];
    logic        exp_chk  [1:5];
    logic [31:0] model_target = '0;

    always @(posedge clk) begin
        logic [31:0] ms;
        if (rst) begin
            k = 0;
        end else if (k == 0) begin
            if (trap_valid) begin
                ms = mem[A_MSTATUS];
                for (int i = 1; i <= 5; i++) begin
                    exp_addr[i] = '0; exp_w[i] = '0; exp_wen[i] = 1'b0; exp_chk[i] = 1'b0;
                end
                if (!trap_is_mret) begin
                    exp_addr[1] = A_MEPC;    exp_w[1] = trap_pc; exp_wen[1] = 1; exp_chk[1] = 1;
                    exp_addr[2] = A_MCAUSE;  exp_w[2] = 32'd11;  exp_wen[2] = 1; exp_chk[2] = 1;
                    exp_addr[3] = A_MSTATUS; exp_wen[3] = 1;     exp_chk[3] = 1;
                    exp_w[3] = (ms & ~32'h1888) | (((ms >> 3) & 32'd1) << 7) | 32'h1800;
                    exp_addr[4] = A_MTVEC;   exp_chk[4] = 1;
                    model_target = mem[A_MTVEC] & ~32'd3;
                    last = 5;
                end else begin
                    exp_addr[1] = A_MSTATUS; exp_wen[1] = 1;     exp_chk[1] = 1;
                    exp_w[1] = (ms & ~32'h1888) | (((ms >> 7) & 32'd1) << 3) | 32'h80;
                    exp_addr[2] = A_MEPC;    exp_chk[2] = 1;
                    model_target = mem[A_MEPC];
                    last = 3;
                end
                k = 1;
            end
        end else begin
            k = (k == last) ? 0 : k + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (k == 0) begin
                check("idle_ready", {31'd0, trap_ready}, 32'd1);
                check("idle_rvalid", {31'd0, redirect_valid}, 32'd0);
                if (trap_valid) begin
                    check("accept_stall", {31'd0, core_stall}, 32'd1);
                    check("accept_wen", {31'd0, csr_w_en}, 32'd0);
                end else begin
                    check("pass_stall", {31'd0, core_stall}, 32'd0);
                    check("pass_wen", {31'd0, csr_w_en}, {31'd0, core_csr_w_en});
                    check("pass_addr", {20'd0, csr_addr}, {20'd0, core_csr_addr});
                    check("pass_r", core_csr_r, csr_r);
                    if (core_csr_w_en) check("pass_w", csr_w, core_csr_w);
                end
            end else begin
                check("seq_ready", {31'd0, trap_ready}, 32'd0);
                check("seq_stall", {31'd0, core_stall}, 32'd1);
                check("seq_core_r", core_csr_r, 32'd0);
                check("seq_rvalid", {31'd0, redirect_valid}, {31'd0, k == last});
                if (k == last) begin
                    check("seq_rpc", redirect_pc, model_target);
                    check("done_wen", {31'd0, csr_w_en}, 32'd0);
                end else begin
                    check("seq_wen", {31'd0, csr_w_en}, {31'd0, exp_wen[k]});
                    if (exp_chk[k]) check("seq_addr", {20'd0, csr_addr}, {20'd0, exp_addr[k]});
                    if (exp_wen[k]) check("seq_w", csr_w, exp_w[k]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic core_wr(input logic [11:0] a, input logic [31:0] v);
        core_csr_addr = a; core_csr_w = v; core_csr_w_en = 1'b1;
        cyc();
        core_csr_w_en = 1'b0;
    endtask

    // Issues one trap starting in the current cycle; returns in the cycle trap_ready is back
    task automatic do_trap(input logic mret, input logic [31:0] pc,
                           output int pulse, output int stalls, output int ready_at);
        pulse = -1; stalls = 0; ready_at = -1;
        trap_valid = 1'b1; trap_is_mret = mret; trap_pc = pc;
        #1;
        if (core_stall) stalls++;
        cyc();
        trap_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            if (redirect_valid) pulse = i;
            if (trap_ready) begin
                ready_at = i;
                break;
            end
            if (core_stall) stalls++;
            cyc();
        end
        if (ready_at < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    int          pulse, stalls, ready_at;
    logic [31:0] rpc_seen;
    bit          seen;

    initial begin
        #12;
        check("rst_ready", {31'd0, trap_ready}, 32'd1);
        check("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_wen", {31'd0, csr_w_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pass-through write then read
        core_wr(A_MTVEC, 32'h1234);
        core_csr_addr = A_MTVEC;
        #1;
        check("pt_read", core_csr_r, 32'h1234);
        check("pt_stall", {31'd0, core_stall}, 32'd0);
        cyc();

        // ecall
        core_wr(A_MTVEC, 32'h8000_0103);
        core_wr(A_MSTATUS, 32'h8);
        do_trap(1'b0, 32'h8000_0010, pulse, stalls, ready_at);
        rpc_seen = redirect_pc;
        check("ecall_pulse", pulse, 32'd5);
        check("ecall_ready", ready_at, 32'd6);
        check("ecall_mepc", mem[A_MEPC], 32'h8000_0010);
        check("ecall_mcause", mem[A_MCAUSE], 32'd11);
        check("ecall_mstatus", mem[A_MSTATUS], 32'h1880);
        check("ecall_rpc", rpc_seen, 32'h8000_0100);
        check("model_ecall_tgt", model_target, 32'h8000_0100);
        cyc();

        // mret
        core_wr(A_MEPC, 32'h8000_0014);
        core_wr(A_MSTATUS, 32'h1880);
        do_trap(1'b1, 32'h0, pulse, stalls, ready_at);
        check("mret_pulse", pulse, 32'd3);
        check("mret_ready", ready_at, 32'd4);
        check("mret_mstatus", mem[A_MSTATUS], 32'h88);
        check("mret_rpc", redirect_pc, 32'h8000_0014);
        check("model_mret_tgt", model_target, 32'h8000_0014);
        cyc();

        // Core write colliding with trap acceptance
        core_csr_addr = A_MEPC; core_csr_w = 32'hDEAD_BEEF; core_csr_w_en = 1'b1;
        do_trap(1'b0, 32'h8000_0040, pulse, stalls, ready_at);
        core_csr_w_en = 1'b0;
        check("coll_stalls", stalls, 32'd6);
        check("coll_mepc", mem[A_MEPC], 32'h8000_0040);
        cyc();

        // Reset during W_CAUSE
        core_wr(A_MCAUSE, 32'h5);
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_pc = 32'h8000_0020;
        cyc();
        trap_valid = 1'b0;
        cyc();
        check("wcause_addr", {20'd0, csr_addr}, {20'd0, A_MCAUSE});
        rst = 1'b1;
        #1;
        check("rstmid_ready", {31'd0, trap_ready}, 32'd1);
        check("rstmid_rvalid", {31'd0, redirect_valid}, 32'd0);
        cyc();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (redirect_valid) seen = 1'b1;
            cyc();
        end
        check("rstmid_no_pulse", {31'd0, seen}, 32'd0);
        check("rstmid_mcause", mem[A_MCAUSE], 32'h5);
        check("rstmid_mepc", mem[A_MEPC], 32'h8000_0020);
        check("rstmid_ready_after", {31'd0, trap_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060075_trap_ctrl.md
# ysyx_23060075_trap_ctrl

Trap sequencer between the decode/execute stage and the CSR file. It turns `ecall` and `mret` into a fixed multi-cycle sequence of single-port CSR accesses: save `mepc` and `mcause`, update `mstatus`, and fetch `mtvec` or `mepc`. It then hands the redirect target to the PC logic. When idle, it forwards ordinary Zicsr accesses from the core to the CSR file unchanged.

## Interface
- `MCAUSE_ECALL`, default 11: value written to `mcause` on `ecall` from M-mode.
- `XLEN`, default `` `ysyx_23060075_ISA_WIDTH `` (32): datapath width.
- `AW`, default `` `ysyx_23060075_CSR_ADDR_WIDTH `` (12): CSR address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `trap_valid`  in  1  trap request from execute.
- `trap_is_mret`  in  1  request kind: 0 = `ecall`, 1 = `mret`; sampled with `trap_valid`.
- `trap_pc`  in  XLEN  PC of the trapping instruction; sampled with `trap_valid`.
- `trap_ready`  out  1  high when in IDLE; the request is accepted on the edge where `trap_valid & trap_ready`.
- `redirect_valid`  out  1  one-cycle pulse: `redirect_pc` is the next fetch PC.
- `redirect_pc`  out  XLEN  registered trap target or return address.
- `core_csr_addr`  in  AW  Zicsr access address from the core.
- `core_csr_w`  in  XLEN  Zicsr write data from the core.
- `core_csr_w_en`  in  1  Zicsr write enable from the core.
- `core_csr_r`  out  XLEN  Zicsr read data returned to the core.
- `core_stall`  out  1  core must hold; its CSR access is not performed.
- `csr_addr`  out  AW  address to the CSR file.
- `csr_w`  out  XLEN  write data to the CSR file.
- `csr_w_en`  out  1  write enable to the CSR file.
- `csr_r`  in  XLEN  combinational read data from the CSR file at `csr_addr`.

## Operation
States: IDLE, W_EPC, W_CAUSE, W_STAT, R_VEC, R_STAT, R_EPC, DONE.

IDLE:
- With `trap_valid` low: the `core_csr_*` inputs pass straight to `csr_*`, `core_csr_r = csr_r`, and `core_stall = 0`.
- With `trap_valid` high: the core path is blocked (`csr_w_en = 0`, `core_stall = 1`).
  - `trap_pc` is latched.
  - Next state is R_STAT if `trap_is_mret`, otherwise W_EPC.

`ecall` path:
- W_EPC: `csr_addr` = MEPC, `csr_w` = latched pc, `csr_w_en` = 1.
- W_CAUSE: `csr_addr` = MCAUSE, `csr_w` = MCAUSE_ECALL, `csr_w_en` = 1.
- W_STAT: `csr_addr` = MSTATUS; write back `csr_r` with these changes:
  - MPIE(bit 7) ← MIE(bit 3)
  - MIE ← 0
  - MPP(bits 12:11) ← 2'b11
  - all other bits unchanged
- R_VEC: `csr_addr` = MTVEC, no write; `redirect_pc` ← {`csr_r`[XLEN-1:2], 2'b00} (direct mode only).

`mret` path:
- R_STAT: `csr_addr` = MSTATUS; write back with these changes:
  - MIE ← MPIE
  - MPIE ← 1
  - MPP ← 2'b00
- R_EPC: `csr_addr` = MEPC, no write; `redirect_pc` ← `csr_r`.

DONE: `redirect_valid` = 1, no CSR access; next state IDLE.

Outside IDLE, `core_stall` = 1 and `core_csr_r` = 0.

## Timing
- Reset values: state IDLE, `redirect_valid` 0, `redirect_pc` 0, latched pc 0. `csr_w_en` follows the IDLE pass-through, so it is 0 unless `core_csr_w_en` is high.
- `ecall`: accepted at edge 0; W_EPC, W_CAUSE, W_STAT, R_VEC occupy cycles 1–4; `redirect_valid` is high in cycle 5. `trap_ready` is high again in cycle 6.
- `mret`: R_STAT is cycle 1, R_EPC cycle 2, `redirect_valid` in cycle 3, ready in cycle 4.
- `trap_valid` held high after acceptance is ignored until `trap_ready` returns; the requester must deassert it after the accepting edge.
- A core CSR access and a trap in the same IDLE cycle: the trap wins, the core access is suppressed and stalled.
- Read-modify-write of `mstatus` completes in one cycle: combinational read, write on the same edge.
- Reset mid-sequence: immediate return to IDLE. Writes already committed stay; no further writes; no `redirect_valid`.

## Structure
- `config.vh` gains:
  - `` `ysyx_23060075_MSTATUS_MIE `` (3)
  - `` `ysyx_23060075_MSTATUS_MPIE `` (7)
  - `` `ysyx_23060075_MSTATUS_MPP_HI `` / `_LO` (12/11)
  - `` `ysyx_23060075_MCAUSE_ECALL_M `` (11)
  - the existing MEPC/MCAUSE/MTVEC/MSTATUS address macros are reused.
- State encoding is a localparam inside the module.
- State, latched pc, `redirect_pc` and `redirect_valid` use `ysyx_23060075_register` instances. No other sub-module.

## Test plan
- `ecall` with `trap_pc` = 0x8000_0010, `mtvec` = 0x8000_0103, `mstatus` = 0x8 → after it:
  - `mepc` = 0x8000_0010, `mcause` = 11, `mstatus` = 0x1880
  - `redirect_pc` = 0x8000_0100
  - `redirect_valid` pulses exactly in cycle 5.
- `mret` with `mepc` = 0x8000_0014, `mstatus` = 0x1880 → `mstatus` = 0x88, `redirect_pc` = 0x8000_0014, pulse in cycle 3.
- IDLE pass-through: core writes 0x1234 to MTVEC and then reads it → `core_csr_r` = 0x1234, `core_stall` = 0 throughout.
- Core write to MEPC asserted in the same cycle as `ecall` accept → core write suppressed, `core_stall` = 1 for 6 cycles, final `mepc` = `trap_pc`.
- `rst` pulsed during W_CAUSE → state IDLE immediately, `mcause` unchanged, no `redirect_valid`, `trap_ready` = 1.
